// File: rtl/mul_iter_unit.sv
// mul_iter_unit
//   Iterative shift-add multiplier for the MUL/MULS/UMULL/UMULLS/SMULL/SMULLS
//   family. One partial-product step per cycle; signed ops multiply the
//   magnitudes and negate the 2W-bit product at the end.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           request, sampled only while idle
//   ALUControl[3:0] op code (000x MUL, 010x UMULL, 011x SMULL; bit0 = S)
//   SrcA, SrcB      multiplicand, multiplier
//   busy            high from the cycle after acceptance through DONE
//   done            one-cycle pulse, results valid from this cycle
//   ResultLo/Hi     product low/high word (Hi is 0 for MUL/MULS)
//   FlagsWrite      pulses with done for S-variants
//   FlagN, FlagZ    held until the next FlagsWrite
module mul_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             FlagsWrite,
    output logic             FlagN,
    output logic             FlagZ
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_p;
    logic [CW-1:0]      r_count;

    logic               w_legal;
    logic               w_signed_in;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_neg_prod;

    // Legal codes: 0000, 0001, 0100..0111
    assign w_legal     = !ALUControl[3] && (ALUControl[2] || !ALUControl[1]);
    assign w_signed_in = (ALUControl[2:1] == 2'b11);

    // Most-negative value maps onto itself, which is the correct unsigned magnitude
    assign w_abs_a = SrcA[WIDTH-1] ? (~SrcA + WIDTH'(1)) : SrcA;
    assign w_abs_b = SrcB[WIDTH-1] ? (~SrcB + WIDTH'(1)) : SrcB;

    // W+1-bit add keeps the carry so it can shift into the accumulator MSB
    assign w_sum      = {1'b0, r_acc} + (r_p[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod     = {r_acc, r_p};
    assign w_neg_prod = ~w_prod + (2*WIDTH)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_p        <= '0;
            r_count    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ResultLo   <= '0;
            ResultHi   <= '0;
            FlagsWrite <= 1'b0;
            FlagN      <= 1'b0;
            FlagZ      <= 1'b0;
        end else begin
            done       <= 1'b0;
            FlagsWrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_op    <= ALUControl[2:0];
                        r_mcand <= w_signed_in ? w_abs_a : SrcA;
                        r_p     <= w_signed_in ? w_abs_b : SrcB;
                        r_neg   <= w_signed_in && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        r_acc   <= '0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Multiplier bits drain out of r_p as product bits shift in
                    {r_acc, r_p} <= {w_sum, r_p[WIDTH-1:1]};
                    r_count      <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH-1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_op[2:1] == 2'b11 && r_neg)
                        {r_acc, r_p} <= w_neg_prod;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    ResultLo <= r_p;
                    ResultHi <= r_op[2] ? r_acc : '0;
                    if (r_op[0]) begin
                        FlagsWrite <= 1'b1;
                        FlagN      <= r_op[2] ? r_acc[WIDTH-1] : r_p[WIDTH-1];
                        FlagZ      <= r_op[2] ? (w_prod == '0) : (r_p == '0);
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_iter_unit.sv
module tb_mul_iter_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, FlagsWrite, FlagN, FlagZ;
    logic [31:0] ResultLo, ResultHi;

    int n_vec = 0;
    int n_err = 0;

    // reference state held across ops
    logic m_n = 1'b0;
    logic m_z = 1'b0;

    mul_iter_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .FlagsWrite(FlagsWrite),
        .FlagN(FlagN), .FlagZ(FlagZ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Product as plain 64-bit arithmetic: sign/zero extend then multiply mod 2^64
    function automatic logic [63:0] ref_prod(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (c[2:1] == 2'b11) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'd0, a};
            eb = {32'd0, b};
        end
        p = ea * eb;
        if (!c[2]) p = {32'd0, p[31:0]};
        return p;
    endfunction

    // spam: pulse start with other operands at cycles 5 and 15 of the op
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit spam);
        logic [63:0] p;
        int cyc;
        p = ref_prod(c, a, b);
        if (c[0]) begin
            m_n = c[2] ? p[63] : p[31];
            m_z = c[2] ? (p == 64'd0) : (p[31:0] == 32'd0);
        end
        @(negedge clk);
        ALUControl = c; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            start = spam && (cyc == 4 || cyc == 14);
            if (start) begin ALUControl = 4'b0100; SrcA = $urandom; SrcB = $urandom; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", 64'(cyc), 64'd34);
        chk("result", {ResultHi, ResultLo}, p);
        chk("flagswrite", {63'd0, FlagsWrite}, {63'd0, c[0]});
        chk("flags", {62'd0, FlagN, FlagZ}, {62'd0, m_n, m_z});
        @(negedge clk);
        chk("done_pulse", {62'd0, done, busy}, 64'd0);
        chk("result_hold", {ResultHi, ResultLo}, p);
    endtask

    task automatic illegal(input logic [3:0] c);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        ALUControl = c; SrcA = $urandom; SrcB = $urandom; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done) seen = 1'b1;
        end
        chk("illegal_ignored", {63'd0, seen}, 64'd0);
    endtask

    initial begin
        logic [3:0] codes [6];
        codes = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        reset = 1'b1; start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, FlagsWrite, FlagN, FlagZ, ResultHi, ResultLo}, 69'd0);
        reset = 1'b0;

        run_op(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(4'b0111, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op(4'b0110, 32'h80000000, 32'h80000000, 1'b0);
        run_op(4'b0100, 32'h80000000, 32'h80000000, 1'b0);
        run_op(4'b0001, 32'h00010000, 32'h00010000, 1'b0);
        run_op(4'b0000, 32'd7, 32'd6, 1'b0);
        run_op(4'b0101, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        illegal(4'b0010);
        illegal(4'b0011);
        illegal(4'b1000);

        // reset mid-operation
        @(negedge clk);
        ALUControl = 4'b0110; SrcA = 32'hDEADBEEF; SrcB = 32'h0BADF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_abort", {busy, done, FlagsWrite, FlagN, FlagZ, ResultHi, ResultLo}, 69'd0);
        m_n = 1'b0; m_z = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_op(4'b0100, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 4))
                0: a = 32'h80000000;
                1: b = 32'd0;
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(codes[$urandom_range(0, 5)], a, b, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
